// File: rtl/mult_seq_ctrl_pkg.sv
// Shared constants for the execute-stage iterative multiplier: ALU encoding,
// sequencer states and the default operand width.
package mult_seq_ctrl_pkg;
    localparam int WIDTH = 32;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        FIX,
        DONE
    } stateT;
endpackage

// File: rtl/mult_seq_neg.sv
// Combinational two's-complement negate of a W-bit value.
module mult_seq_neg #(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    output logic [W-1:0] y
);
    assign y = ~a + W'(1);
endmodule

// File: rtl/mult_seq_ctrl.sv
// MULT/MULTU sequencer: WIDTH-step shift-add on the shared execute ALU,
// stalls the front of the pipe while running and owns HI/LO.
module mult_seq_ctrl #(
    parameter int         WIDTH   = mult_seq_ctrl_pkg::WIDTH,
    parameter logic [2:0] ALU_ADD = mult_seq_ctrl_pkg::ALU_ADD
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sgn,
    input  logic             flush,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic [WIDTH-1:0] alu_y,
    output logic             alu_own,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_f,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    import mult_seq_ctrl_pkg::*;

    localparam int CW = $clog2(WIDTH) + 1;

    stateT             state;
    logic [WIDTH-1:0]  opA, opB, negA, negB, magA, magB;
    logic [WIDTH-1:0]  mcand, accHi, accLo;
    logic [2*WIDTH-1:0] prod, negProd;
    logic [CW-1:0]     count;
    logic              sgnR, neg, carry;

    mult_seq_neg #(.W(WIDTH))   uNegA (.a(opA),  .y(negA));
    mult_seq_neg #(.W(WIDTH))   uNegB (.a(opB),  .y(negB));
    mult_seq_neg #(.W(2*WIDTH)) uNegP (.a(prod), .y(negProd));

    // The most negative value negates to itself, which read unsigned is 2^(WIDTH-1).
    assign magA  = (sgnR && opA[WIDTH-1]) ? negA : opA;
    assign magB  = (sgnR && opB[WIDTH-1]) ? negB : opB;
    assign prod  = {accHi, accLo};
    // The ALU drops the carry-out; an unsigned wrap shows up as a sum below operand A.
    assign carry = (alu_y < accHi);

    always_comb begin
        alu_own = (state == RUN);
        alu_a   = alu_own ? accHi : '0;
        alu_b   = (alu_own && accLo[0]) ? mcand : '0;
        alu_f   = alu_own ? ALU_ADD : 3'b000;
        busy    = (state == LOAD) || (state == RUN) || (state == FIX);
        stall   = busy || ((state == IDLE) && start && !flush);
        done    = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            opA   <= '0;
            opB   <= '0;
            mcand <= '0;
            accHi <= '0;
            accLo <= '0;
            count <= '0;
            sgnR  <= 1'b0;
            neg   <= 1'b0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            unique case (state)
                IDLE: if (start && !flush) begin
                    opA   <= src_a;
                    opB   <= src_b;
                    sgnR  <= sgn;
                    neg   <= sgn && (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
                    state <= LOAD;
                end
                LOAD: if (flush) state <= IDLE;
                else begin
                    mcand <= magA;
                    accHi <= '0;
                    accLo <= magB;
                    count <= '0;
                    state <= RUN;
                end
                RUN: if (flush) state <= IDLE;
                else begin
                    accHi <= {carry, alu_y[WIDTH-1:1]};
                    accLo <= {alu_y[0], accLo[WIDTH-1:1]};
                    count <= count + CW'(1);
                    if (count == CW'(WIDTH - 1)) state <= FIX;
                end
                FIX: if (flush) state <= IDLE;
                else begin
                    {hi, lo} <= neg ? negProd : prod;
                    state    <= DONE;
                end
                // The instruction that started us advances this cycle, so start is ignored.
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
